// File: rtl/vending_machine_a_b.sv
// vending_machine_a_b
//   Two-item coin vending controller. Credit is accumulated in 5-unit steps
//   in a 3-bit state register (S0..S20 = 0..4 units of 5). When a clock edge
//   sees no coin and the credit covers the selected item's price, the item is
//   dispensed and the change is returned. Both appear as a one-cycle
//   registered pulse, and the credit is cleared.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active low
//   coin[1:0]   00 none, 01 five, 10 ten, 11 invalid (ignored)
//   sel_item    0 = Item A, 1 = Item B; only looked at on a vend edge
//   dispense_A  one-cycle pulse, Item A vended
//   dispense_B  one-cycle pulse, Item B vended
//   change[1:0] change in fives (00 none, 01 five, 10 ten), valid with a dispense
module vending_machine_a_b #(
  parameter int PRICE_A  = 10,
  parameter int PRICE_B  = 15,
  parameter int MAX_CRED = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin,
  input  logic       sel_item,
  output logic       dispense_A,
  output logic       dispense_B,
  output logic [1:0] change
);

  typedef enum logic [2:0] {
    S0  = 3'd0,
    S5  = 3'd1,
    S10 = 3'd2,
    S15 = 3'd3,
    S20 = 3'd4
  } state_t;

  // All arithmetic is done in units of 5, so the state code is the credit.
  localparam logic [2:0] MAX_U = 3'(MAX_CRED / 5);
  localparam logic [2:0] PA_U  = 3'(PRICE_A / 5);
  localparam logic [2:0] PB_U  = 3'(PRICE_B / 5);

  state_t     state, state_nxt;
  logic       disp_a_nxt, disp_b_nxt;
  logic [1:0] change_nxt;
  logic [2:0] units, add_u, price_u;
  logic [3:0] sum_u;

  always_comb begin
    state_nxt  = state;
    disp_a_nxt = 1'b0;
    disp_b_nxt = 1'b0;
    change_nxt = 2'b00;
    units      = state;
    add_u      = (coin == 2'b01) ? 3'd1 : (coin == 2'b10) ? 3'd2 : 3'd0;
    sum_u      = {1'b0, units} + {1'b0, add_u};
    price_u    = sel_item ? PB_U : PA_U;

    if (coin == 2'b01 || coin == 2'b10) begin
      // A coin that would overflow the ceiling is refused; credit holds.
      if (sum_u <= {1'b0, MAX_U}) state_nxt = state_t'(sum_u[2:0]);
    end else if (coin == 2'b00 && units >= price_u) begin
      // Vend only on an edge with no coin present. An invalid code (11) counts
      // as a coin being present, so it neither adds credit nor triggers a vend.
      disp_a_nxt = ~sel_item;
      disp_b_nxt = sel_item;
      change_nxt = 2'(units - price_u);
      state_nxt  = S0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S0;
      dispense_A <= 1'b0;
      dispense_B <= 1'b0;
      change     <= 2'b00;
    end else begin
      state      <= state_nxt;
      dispense_A <= disp_a_nxt;
      dispense_B <= disp_b_nxt;
      change     <= change_nxt;
    end
  end

endmodule

// File: tb/tb_vending_machine_a_b.sv
module tb_vending_machine_a_b;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin;
  logic       sel_item;
  logic       dispense_A, dispense_B;
  logic [1:0] change;

  int errors = 0;
  int checks = 0;

  vending_machine_a_b dut (
    .clk(clk), .rst(rst), .coin(coin), .sel_item(sel_item),
    .dispense_A(dispense_A), .dispense_B(dispense_B), .change(change)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [1:0] c;
    logic       s;
    logic       ea;
    logic       eb;
    logic [1:0] ech;
    logic [2:0] est;
  } vec_t;

  vec_t tbl[$];

  // Reference model: the credit is a plain integer in currency units.
  int m_credit;
  int m_a, m_b, m_ch;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s idx=%0d got=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  // Drive one set of inputs, let one rising edge pass, sample just after it.
  task automatic step(input logic r, input logic [1:0] c, input logic s);
    @(negedge clk);
    rst = r; coin = c; sel_item = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int idx, input int ea, input int eb,
                           input int ech, input int est);
    chk({tag, "_dispA"}, idx, int'(dispense_A), ea);
    chk({tag, "_dispB"}, idx, int'(dispense_B), eb);
    chk({tag, "_change"}, idx, int'(change), ech);
    chk({tag, "_state"}, idx, int'(dut.state), est);
  endtask

  task automatic model(input logic r, input logic [1:0] c, input logic s);
    int v, price;
    m_a = 0; m_b = 0; m_ch = 0;
    if (!r) begin
      m_credit = 0;
    end else if (c == 2'b01 || c == 2'b10) begin
      v = (c == 2'b01) ? 5 : 10;
      if (m_credit + v <= 20) m_credit += v;
    end else if (c == 2'b00) begin
      price = s ? 15 : 10;
      if (m_credit >= price) begin
        if (s) m_b = 1; else m_a = 1;
        m_ch = (m_credit - price) / 5;
        m_credit = 0;
      end
    end
  endtask

  initial begin
    bit seen;
    logic       rr, ss;
    logic [1:0] cc;

    rst = 1'b0; coin = 2'b00; sel_item = 1'b0;

    //             r  coin   s  A  B  chg    state
    // reset held low for two clocks, then idle
    tbl.push_back('{0, 2'b00, 0, 0, 0, 2'b00, 3'd0});
    tbl.push_back('{0, 2'b00, 0, 0, 0, 2'b00, 3'd0});
    tbl.push_back('{1, 2'b00, 0, 0, 0, 2'b00, 3'd0});
    // 10 then vend A, exact price
    tbl.push_back('{1, 2'b10, 0, 0, 0, 2'b00, 3'd2});
    tbl.push_back('{1, 2'b00, 0, 1, 0, 2'b00, 3'd0});
    tbl.push_back('{1, 2'b00, 0, 0, 0, 2'b00, 3'd0});
    // 10 + 5 -> B, no change
    tbl.push_back('{1, 2'b10, 1, 0, 0, 2'b00, 3'd2});
    tbl.push_back('{1, 2'b01, 1, 0, 0, 2'b00, 3'd3});
    tbl.push_back('{1, 2'b00, 1, 0, 1, 2'b00, 3'd0});
    // 10 + 10 -> B, change five
    tbl.push_back('{1, 2'b10, 1, 0, 0, 2'b00, 3'd2});
    tbl.push_back('{1, 2'b10, 1, 0, 0, 2'b00, 3'd4});
    tbl.push_back('{1, 2'b00, 1, 0, 1, 2'b01, 3'd0});
    // 5 + 10 with sel toggling during coins -> A, change five
    tbl.push_back('{1, 2'b01, 1, 0, 0, 2'b00, 3'd1});
    tbl.push_back('{1, 2'b10, 1, 0, 0, 2'b00, 3'd3});
    tbl.push_back('{1, 2'b00, 0, 1, 0, 2'b01, 3'd0});
    // 5,5,5 back to back: no A vend at credit 10, then B
    tbl.push_back('{1, 2'b01, 0, 0, 0, 2'b00, 3'd1});
    tbl.push_back('{1, 2'b01, 0, 0, 0, 2'b00, 3'd2});
    tbl.push_back('{1, 2'b01, 1, 0, 0, 2'b00, 3'd3});
    tbl.push_back('{1, 2'b00, 1, 0, 1, 2'b00, 3'd0});
    // credit 20, further 10/5 refused, 11 ignored, then A with change ten
    tbl.push_back('{1, 2'b10, 0, 0, 0, 2'b00, 3'd2});
    tbl.push_back('{1, 2'b10, 0, 0, 0, 2'b00, 3'd4});
    tbl.push_back('{1, 2'b10, 0, 0, 0, 2'b00, 3'd4});
    tbl.push_back('{1, 2'b01, 0, 0, 0, 2'b00, 3'd4});
    tbl.push_back('{1, 2'b11, 0, 0, 0, 2'b00, 3'd4});
    tbl.push_back('{1, 2'b00, 0, 1, 0, 2'b10, 3'd0});
    // 11 at S0; 11 with credit 10 is not a vend edge; B unaffordable holds
    tbl.push_back('{1, 2'b11, 0, 0, 0, 2'b00, 3'd0});
    tbl.push_back('{1, 2'b10, 0, 0, 0, 2'b00, 3'd2});
    tbl.push_back('{1, 2'b11, 0, 0, 0, 2'b00, 3'd2});
    tbl.push_back('{1, 2'b00, 1, 0, 0, 2'b00, 3'd2});
    tbl.push_back('{1, 2'b01, 1, 0, 0, 2'b00, 3'd3});
    // reset on what would be a vend edge: credit lost, nothing dispensed
    tbl.push_back('{0, 2'b00, 1, 0, 0, 2'b00, 3'd0});
    tbl.push_back('{1, 2'b00, 1, 0, 0, 2'b00, 3'd0});
    tbl.push_back('{1, 2'b00, 0, 0, 0, 2'b00, 3'd0});

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].c, tbl[i].s);
      check_all("vec", i, int'(tbl[i].ea), int'(tbl[i].eb), int'(tbl[i].ech), int'(tbl[i].est));
    end

    // Reset held low while coins keep arriving: credit must stay at zero.
    step(1, 2'b10, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 2'b01, 0);
      check_all("rst_coins", k, 0, 0, 0, 0);
    end

    // Bounded wait for a vend after 10+10 with Item A selected.
    step(1, 2'b10, 0);
    step(1, 2'b10, 0);
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      step(1, 2'b00, 0);
      if (dispense_A) begin
        seen = 1'b1;
        chk("wait_change", k, int'(change), 2);
        chk("wait_dispB", k, int'(dispense_B), 0);
      end
    end
    chk("wait_vend_seen", 0, int'(seen), 1);
    step(1, 2'b00, 0);
    check_all("after_vend", 0, 0, 0, 0, 0);

    // Randomised run against the reference model, starting from reset.
    step(0, 2'b00, 0);
    m_credit = 0;
    for (int n = 0; n < 1500; n++) begin
      rr = ($urandom_range(0, 39) != 0);
      cc = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) cc = 2'b00;
      ss = 1'($urandom_range(0, 1));
      step(rr, cc, ss);
      model(rr, cc, ss);
      check_all("rand", n, m_a, m_b, m_ch, m_credit / 5);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
